if_queue: RTL and testbench
===========================

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1: width of the occupancy count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-006 SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-007 SHALL have port in_pc, input, 64 bits: PC of the presented instruction.
REQ-008 SHALL have port in_instr, input, 32 bits: the presented instruction word.
REQ-009 SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port out_pc, output, 64 bits: PC of the head entry.
REQ-012 SHALL have port out_instr, output, 32 bits: instruction word of the head entry.
REQ-013 SHALL have port out_ready, input, 1 bit: the decode stage consumes the head entry.
REQ-014 SHALL have port count, output, CW bits: current occupancy, 0..DEPTH.

Function
REQ-015 SHALL operate as a circular FIFO built from a storage array, a write pointer, a read pointer and an occupancy counter; both pointers wrap modulo DEPTH.
REQ-016 SHALL perform an enqueue when in_valid=1, in_ready=1 and flush=0: {in_pc, in_instr} is written at the write pointer, and the write pointer advances by 1.
REQ-017 SHALL perform a dequeue when out_valid=1, out_ready=1 and flush=0: the read pointer advances by 1.
REQ-018 SHALL drive in_ready = (count != DEPTH), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 SHALL drive out_valid = (count != 0) and drive out_pc/out_instr from the entry at the read pointer, with no combinational path from any in_* port.
REQ-020 SHALL have a latency of one cycle: an entry enqueued at edge N is visible on out_* after edge N, and the queue never passes in_* through to out_* in the same cycle.
REQ-021 SHALL update count as follows: enqueue only -> +1; dequeue only -> -1; simultaneous enqueue and dequeue -> unchanged.
REQ-022 SHALL, when full (count=DEPTH), hold in_ready=0 so no enqueue occurs, even if a dequeue happens in the same cycle; the freed slot becomes usable on the next cycle.
REQ-023 SHALL, when empty (count=0), perform no dequeue regardless of out_ready; an enqueue into an empty queue sets out_valid=1 on the next cycle.
REQ-024 SHALL give flush priority over everything else: at an edge with flush=1, both pointers and count go to 0, and any enqueue or dequeue in that cycle is discarded.
REQ-025 SHALL preserve FIFO order exactly: the out_* sequence equals the accepted in_* sequence, minus the entries discarded by flush.
REQ-026 SHALL never output stale data as valid: when out_valid=0, out_pc and out_instr are don't-care.

Reset
REQ-027 SHALL, while rst=0, immediately and asynchronously force write pointer=0, read pointer=0 and count=0, giving out_valid=0 and in_ready=1.
REQ-028 SHALL leave the storage array un-reset; its contents are irrelevant while count=0.
REQ-029 SHALL, if reset asserts mid-operation, discard every queued entry and block any in-flight enqueue or dequeue from taking effect.
REQ-030 SHALL resume normal operation at the first rising clk edge after rst returns to 1.

Verification
REQ-031 SHALL pass this scenario: reset, then enqueue PC 0x80000000/instr 0x00000013 with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000013, count=1.
REQ-032 SHALL pass this scenario: enqueue 4 consecutive entries (PC 0x80000000..0x8000000C) with out_ready=0 -> count=4 and in_ready=0; a 5th presented entry is not accepted; then out_ready=1 for 4 cycles -> PCs emerge in order, then count=0 and out_valid=0.
REQ-033 SHALL pass this scenario: hold count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2 and the output PCs are strictly sequential across pointer wrap-around.
REQ-034 SHALL pass this scenario: count=3 with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, and the presented entry is not stored.
REQ-035 SHALL pass this scenario: count=4 with out_ready=1 and in_valid=1 -> that cycle dequeues only, count becomes 3, and the entry is accepted on the following cycle.
REQ-036 SHALL pass this scenario: rst pulsed low between clock edges while count=2 -> out_valid=0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_queue_if
//  Purpose  : Handshake bundle between the fetch stage, the instruction queue
//             and the decode stage.
//  Ports    : none (signal container)
//     flush                     - discard all queued entries
//     in_valid/in_pc/in_instr   - fetch stage presents an instruction
//     in_ready                  - queue accepts an entry this cycle
//     out_valid/out_pc/out_instr- head entry of the queue
//     out_ready                 - decode stage consumes the head entry
//     count                     - current occupancy, 0..DEPTH
//  Modports : slave  - the queue itself
//             master - the producer/consumer side driving the queue
//  Revision : 1.0 - initial release
// ============================================================================
interface if_queue_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) ();
   logic          flush;
   logic          in_valid;
   logic [63:0]   in_pc;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          out_valid;
   logic [63:0]   out_pc;
   logic [31:0]   out_instr;
   logic          out_ready;
   logic [CW-1:0] count;

   modport slave (
      input  flush,
      input  in_valid,
      input  in_pc,
      input  in_instr,
      output in_ready,
      output out_valid,
      output out_pc,
      output out_instr,
      input  out_ready,
      output count
   );

   modport master (
      output flush,
      output in_valid,
      output in_pc,
      output in_instr,
      input  in_ready,
      input  out_valid,
      input  out_pc,
      input  out_instr,
      output out_ready,
      input  count
   );
endinterface : if_queue_if
`default_nettype wire

// File: rtl/if_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_queue
//  Purpose  : Instruction fetch queue. Circular FIFO of {pc, instr} entries
//             with a write pointer, read pointer and occupancy counter.
//             One cycle latency from enqueue to visibility; ready/valid are
//             decoded from registered occupancy only.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous reset, active low
//             q   - if_queue_if.slave handshake bundle
//  Revision : 1.0 - initial release
// ============================================================================
module if_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  wire logic clk,
   input  wire logic rst,
   if_queue_if.slave q
);

   localparam int c_AW = $clog2(DEPTH);

   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [CW-1:0]   r_count;

   // Storage is deliberately left un-reset; nothing reads it while empty.
   logic [63:0]     r_mem_pc    [DEPTH];
   logic [31:0]     r_mem_instr [DEPTH];

   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_enq;
   logic            w_deq;

   assign w_in_ready  = (r_count != CW'(DEPTH));
   assign w_out_valid = (r_count != '0);

   // Flush suppresses both transfers so the counter and pointers see a clean
   // clear with no side effect from that cycle's handshakes.
   assign w_enq = q.in_valid  & w_in_ready  & ~q.flush;
   assign w_deq = w_out_valid & q.out_ready & ~q.flush;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (q.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + CW'(1);
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem_pc[r_wr_ptr]    <= q.in_pc;
         r_mem_instr[r_wr_ptr] <= q.in_instr;
      end
   end

   assign q.in_ready  = w_in_ready;
   assign q.out_valid = w_out_valid;
   assign q.out_pc    = r_mem_pc[r_rd_ptr];
   assign q.out_instr = r_mem_instr[r_rd_ptr];
   assign q.count     = r_count;

endmodule : if_queue
`default_nettype wire

// File: tb/tb_if_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_queue
//  Purpose  : Directed self-checking bench for if_queue (DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_queue;

   localparam int c_DEPTH = 4;
   localparam int c_CW    = 3;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   if_queue_if #(.DEPTH(c_DEPTH), .CW(c_CW)) qif ();

   if_queue #(.DEPTH(c_DEPTH), .CW(c_CW)) dut (
      .clk (clk),
      .rst (rst),
      .q   (qif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge; all checks and
   // input changes happen there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      qif.flush     = 1'b0;
      qif.in_valid  = 1'b0;
      qif.in_pc     = 64'h0;
      qif.in_instr  = 32'h0;
      qif.out_ready = 1'b0;
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] ins);
      qif.in_valid = 1'b1;
      qif.in_pc    = pc;
      qif.in_instr = ins;
      step();
      qif.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      step();
      n_total++;
      if (qif.count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", qif.count);
      else n_pass++;
      n_total++;
      if (qif.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", qif.out_valid);
      else n_pass++;
      n_total++;
      if (qif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", qif.in_ready);
      else n_pass++;
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      push(64'h8000_0000, 32'h0000_0013);
      n_total++;
      if (qif.out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", qif.out_valid);
      else n_pass++;
      n_total++;
      if (qif.out_pc !== 64'h8000_0000) $display("FAIL single_pc: got %h expected 80000000", qif.out_pc);
      else n_pass++;
      n_total++;
      if (qif.out_instr !== 32'h0000_0013) $display("FAIL single_instr: got %h expected 00000013", qif.out_instr);
      else n_pass++;
      n_total++;
      if (qif.count !== 3'd1) $display("FAIL single_count: got %0d expected 1", qif.count);
      else n_pass++;
      qif.out_ready = 1'b1;
      step();
      qif.out_ready = 1'b0;
      n_total++;
      if (qif.count !== 3'd0 || qif.out_valid !== 1'b0)
         $display("FAIL single_drain: got count=%0d valid=%b expected 0/0", qif.count, qif.out_valid);
      else n_pass++;
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) push(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
      n_total++;
      if (qif.count !== 3'd4) $display("FAIL full_count: got %0d expected 4", qif.count);
      else n_pass++;
      n_total++;
      if (qif.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", qif.in_ready);
      else n_pass++;
      push(64'h8000_0010, 32'h104);
      n_total++;
      if (qif.count !== 3'd4) $display("FAIL full_reject: got %0d expected 4", qif.count);
      else n_pass++;
      qif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (qif.out_pc !== 64'h8000_0000 + 64'(4 * i) || qif.out_instr !== 32'h100 + 32'(i))
            $display("FAIL full_order%0d: got pc=%h instr=%h expected pc=%h instr=%h", i,
                     qif.out_pc, qif.out_instr, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
         else n_pass++;
         step();
      end
      qif.out_ready = 1'b0;
      n_total++;
      if (qif.count !== 3'd0 || qif.out_valid !== 1'b0)
         $display("FAIL full_empty: got count=%0d valid=%b expected 0/0", qif.count, qif.out_valid);
      else n_pass++;
   endtask

   task automatic test_wrap();
      push(64'h1000, 32'hA0);
      push(64'h1004, 32'hA1);
      qif.in_valid  = 1'b1;
      qif.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         qif.in_pc    = 64'h1000 + 64'(4 * (k + 2));
         qif.in_instr = 32'hA0 + 32'(k + 2);
         n_total++;
         if (qif.out_pc !== 64'h1000 + 64'(4 * k))
            $display("FAIL wrap_pc%0d: got %h expected %h", k, qif.out_pc, 64'h1000 + 64'(4 * k));
         else n_pass++;
         step();
         n_total++;
         if (qif.count !== 3'd2) $display("FAIL wrap_count%0d: got %0d expected 2", k, qif.count);
         else n_pass++;
      end
      qif.in_valid = 1'b0;
      for (int k = 10; k < 12; k++) begin
         n_total++;
         if (qif.out_pc !== 64'h1000 + 64'(4 * k))
            $display("FAIL wrap_tail%0d: got %h expected %h", k, qif.out_pc, 64'h1000 + 64'(4 * k));
         else n_pass++;
         step();
      end
      qif.out_ready = 1'b0;
      n_total++;
      if (qif.count !== 3'd0) $display("FAIL wrap_empty: got %0d expected 0", qif.count);
      else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push(64'h2000 + 64'(4 * i), 32'hB0 + 32'(i));
      n_total++;
      if (qif.count !== 3'd3) $display("FAIL flush_pre: got %0d expected 3", qif.count);
      else n_pass++;
      qif.flush     = 1'b1;
      qif.in_valid  = 1'b1;
      qif.in_pc     = 64'h2100;
      qif.in_instr  = 32'hBF;
      qif.out_ready = 1'b1;
      step();
      idle_inputs();
      n_total++;
      if (qif.count !== 3'd0 || qif.out_valid !== 1'b0)
         $display("FAIL flush_clear: got count=%0d valid=%b expected 0/0", qif.count, qif.out_valid);
      else n_pass++;
      step();
      n_total++;
      if (qif.count !== 3'd0) $display("FAIL flush_not_stored: got %0d expected 0", qif.count);
      else n_pass++;
      push(64'h2200, 32'hC0);
      n_total++;
      if (qif.out_pc !== 64'h2200 || qif.count !== 3'd1)
         $display("FAIL flush_resume: got pc=%h count=%0d expected 2200/1", qif.out_pc, qif.count);
      else n_pass++;
      qif.out_ready = 1'b1;
      step();
      qif.out_ready = 1'b0;
   endtask

   task automatic test_full_deq();
      for (int i = 0; i < 4; i++) push(64'h3000 + 64'(4 * i), 32'hD0 + 32'(i));
      qif.out_ready = 1'b1;
      qif.in_valid  = 1'b1;
      qif.in_pc     = 64'h3010;
      qif.in_instr  = 32'hD4;
      step();
      n_total++;
      if (qif.count !== 3'd3 || qif.out_pc !== 64'h3004)
         $display("FAIL fulldeq_first: got count=%0d pc=%h expected 3/3004", qif.count, qif.out_pc);
      else n_pass++;
      qif.out_ready = 1'b0;
      step();
      qif.in_valid = 1'b0;
      n_total++;
      if (qif.count !== 3'd4) $display("FAIL fulldeq_accept: got %0d expected 4", qif.count);
      else n_pass++;
      qif.out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         n_total++;
         if (qif.out_pc !== 64'h3000 + 64'(4 * i))
            $display("FAIL fulldeq_order%0d: got %h expected %h", i, qif.out_pc, 64'h3000 + 64'(4 * i));
         else n_pass++;
         step();
      end
      qif.out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      push(64'h4000, 32'hE0);
      push(64'h4004, 32'hE1);
      n_total++;
      if (qif.count !== 3'd2) $display("FAIL areset_pre: got %0d expected 2", qif.count);
      else n_pass++;
      qif.in_valid  = 1'b1;
      qif.in_pc     = 64'h4008;
      qif.out_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if (qif.count !== 3'd0 || qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1)
         $display("FAIL areset_immediate: got count=%0d valid=%b ready=%b expected 0/0/1",
                  qif.count, qif.out_valid, qif.in_ready);
      else n_pass++;
      step();
      n_total++;
      if (qif.count !== 3'd0) $display("FAIL areset_blocked: got %0d expected 0", qif.count);
      else n_pass++;
      rst = 1'b1;
      idle_inputs();
      push(64'h5000, 32'hF0);
      n_total++;
      if (qif.out_pc !== 64'h5000 || qif.count !== 3'd1)
         $display("FAIL areset_resume: got pc=%h count=%0d expected 5000/1", qif.out_pc, qif.count);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_full();
      test_wrap();
      test_flush();
      test_full_deq();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_if_queue
`default_nettype wire
